// File: rtl/bus_mem_pkg.sv
// Shared definitions for the _6502 bus memory responder.
// Contents: loader/boot state encoding, default bus widths, and the value
// driven on cpu_di while the CPU is writing.
package bus_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    localparam logic [7:0] CPU_DI_WE_VAL = 8'h00;

    typedef enum logic [2:0] {
        S_ADDR_LO  = 3'd0,
        S_ADDR_HI  = 3'd1,
        S_DATA     = 3'd2,
        S_RELEASE  = 3'd3,
        S_RUN      = 3'd4
    } bm_state_t;

endpackage

// File: rtl/bus_mem_ram.sv
// RAM behind the _6502 bus: one write port shared by loader and CPU, and one
// asynchronous read port at the CPU address.
// Ports:
//   clk                 clock
//   ld_we/addr/data     loader write request (wins when asserted)
//   cpu_we/addr/data    CPU write request, already qualified by the caller
//   rd_data             combinational read of mem[cpu_addr]
module bus_mem_ram
    import bus_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Loader and CPU are never active in the same state, so the priority
    // here only matters for robustness.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cpu_addr;
        wr_data = cpu_data;
        if (ld_we) begin
            wr_en   = 1'b1;
            wr_addr = ld_addr;
            wr_data = ld_data;
        end else if (cpu_we) begin
            wr_en   = 1'b1;
        end
    end

    // No reset: contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[cpu_addr];

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the _6502 core. Holds the 64 KiB RAM and a
// byte-stream loader that fills memory while the CPU is held in reset, then
// releases the CPU after RST_CYCLES clocks.
// Stream: addr lo, addr hi, data bytes...; ld_last ends the stream.
// Ports:
//   clk, reset (sync, active-low)
//   cpu_ab/cpu_do/cpu_we in, cpu_di out, cpu_reset out (active-high)
//   ld_valid/ld_data/ld_last in, ld_ready out, load_done out
// Optional: define BUS_MEM_WP_EN to block CPU writes at or above ROM_BASE.
//
// state     | meaning
// ----------+----------------------------------------------
// S_ADDR_LO | waiting for start address low byte
// S_ADDR_HI | waiting for start address high byte
// S_DATA    | writing data bytes at ptr, ptr increments
// S_RELEASE | stream done, CPU still in reset, counting down
// S_RUN     | CPU running, loader closed until reset
module bus_mem_responder
    import bus_mem_pkg::*;
#(
    parameter int              ADDR_W     = ADDR_W_DEF,
    parameter int              DATA_W     = DATA_W_DEF,
    parameter int              RST_CYCLES = 2,
    parameter logic [15:0]     ROM_BASE   = 16'hE000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_ab,
    input  logic [DATA_W-1:0] cpu_do,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_di,
    output logic              cpu_reset,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              load_done
);

    bm_state_t         state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [3:0]        rel_cnt, rel_cnt_nxt;
    logic              ld_fire;
    logic              ld_we;
    logic              cpu_wp;
    logic              cpu_wr;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_ADDR_LO;
            ptr     <= '0;
            rel_cnt <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            rel_cnt <= rel_cnt_nxt;
        end
    end

    assign ld_ready = (state == S_ADDR_LO) || (state == S_ADDR_HI) || (state == S_DATA);
    assign ld_fire  = ld_valid && ld_ready;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        rel_cnt_nxt = rel_cnt;
        ld_we       = 1'b0;
        case (state)
            S_ADDR_LO: if (ld_fire) begin
                ptr_nxt[7:0] = ld_data;
                state_nxt    = ld_last ? S_RELEASE : S_ADDR_HI;
            end
            S_ADDR_HI: if (ld_fire) begin
                ptr_nxt[ADDR_W-1:8] = ld_data[ADDR_W-9:0];
                state_nxt           = ld_last ? S_RELEASE : S_DATA;
            end
            S_DATA: if (ld_fire) begin
                ld_we   = 1'b1;
                ptr_nxt = ptr + 1'b1;
                if (ld_last) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (rel_cnt == 4'd0) begin
                    state_nxt = S_RUN;
                end else begin
                    rel_cnt_nxt = rel_cnt - 4'd1;
                end
            end
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_ADDR_LO;
        endcase
        // Preload the down-counter on entry so S_RELEASE lasts RST_CYCLES clocks.
        if (state != S_RELEASE && state_nxt == S_RELEASE) begin
            rel_cnt_nxt = 4'(RST_CYCLES - 1);
        end
    end

`ifdef BUS_MEM_WP_EN
    assign cpu_wp = (cpu_ab >= ROM_BASE[ADDR_W-1:0]);
`else
    logic unused_rom_base;
    assign unused_rom_base = ^ROM_BASE;
    assign cpu_wp          = 1'b0;
`endif

    // Both write sources are gated by reset so a byte presented while
    // reset is low never lands in memory.
    assign cpu_wr = reset && cpu_we && (state == S_RUN) && !cpu_wp;

    bus_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk      (clk),
        .ld_we    (ld_we && reset),
        .ld_addr  (ptr),
        .ld_data  (ld_data),
        .cpu_we   (cpu_wr),
        .cpu_addr (cpu_ab),
        .cpu_data (cpu_do),
        .rd_data  (rd_data)
    );

    assign cpu_di    = cpu_we ? CPU_DI_WE_VAL : rd_data;
    assign cpu_reset = (state != S_RUN);
    assign load_done = (state == S_RUN);

endmodule

// File: tb/tb_bus_mem_responder.sv
module tb_bus_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_reset;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        load_done;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    bus_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ab    (cpu_ab),
        .cpu_do    (cpu_do),
        .cpu_we    (cpu_we),
        .cpu_di    (cpu_di),
        .cpu_reset (cpu_reset),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .load_done (load_done)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        cpu_we   = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic read_mem(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        cpu_we = 1'b0;
        cpu_ab = a;
        #1;
        d = cpu_di;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_we = 1'b1;
        cpu_ab = a;
        cpu_do = d;
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (!load_done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, {15'd0, load_done}, 16'd1);
    endtask

    logic [7:0] rd;
    logic [7:0] prog [0:9];

    initial begin
        reset    = 1'b0;
        cpu_ab   = '0;
        cpu_do   = '0;
        cpu_we   = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        prog[0] = 8'hA2; prog[1] = 8'h05; prog[2] = 8'hA0; prog[3] = 8'h0B; prog[4] = 8'hBD;
        prog[5] = 8'h07; prog[6] = 8'h05; prog[7] = 8'h99; prog[8] = 8'h10; prog[9] = 8'h05;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
        check("rst_ld_ready",  {15'd0, ld_ready},  16'd1);
        check("rst_load_done", {15'd0, load_done}, 16'd0);
        do_reset();

        // Program load at 0x0000
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(prog[i], (i == 9));
        check("rel_ld_ready", {15'd0, ld_ready},  16'd0);
        check("rel_cpu_rst0", {15'd0, cpu_reset}, 16'd1);
        @(posedge clk); #1;
        check("rel_cpu_rst1", {15'd0, cpu_reset}, 16'd1);
        @(posedge clk); #1;
        check("rel_cpu_rst2", {15'd0, cpu_reset}, 16'd0);
        check("run_load_done", {15'd0, load_done}, 16'd1);
        check("run_ld_ready", {15'd0, ld_ready},  16'd0);
        for (int i = 0; i < 10; i++) begin
            read_mem(16'(i), rd);
            check($sformatf("prog_%0d", i), {8'd0, rd}, {8'd0, prog[i]});
        end

        // CPU write/read in S_RUN
        @(negedge clk);
        cpu_we = 1'b1; cpu_ab = 16'h051B; cpu_do = 8'h16;
        #1;
        check("di_during_we", {8'd0, cpu_di}, 16'h0000);
        @(posedge clk); #1;
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        check("cpu_rd_051b", {8'd0, cpu_di}, 16'h0016);

        // Write protect behaviour
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hAA, 1'b1);
        wait_run("wp_wait_run");
        cpu_write(16'hE000, 8'h00);
        read_mem(16'hE000, rd);
`ifdef BUS_MEM_WP_EN
        check("wp_e000", {8'd0, rd}, 16'h00AA);
`else
        check("wp_e000", {8'd0, rd}, 16'h0000);
`endif

        // Address wrap-around
        do_reset();
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        wait_run("wrap_wait_run");
        read_mem(16'hFFFF, rd);
        check("wrap_ffff", {8'd0, rd}, 16'h0011);
        read_mem(16'h0000, rd);
        check("wrap_0000", {8'd0, rd}, 16'h0022);

        // CPU write dropped while loading
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h3C, 1'b0);
        cpu_write(16'h0300, 8'h55);
        send_byte(8'h01, 1'b1);
        wait_run("drop_wait_run");
        read_mem(16'h0300, rd);
        check("drop_0300", {8'd0, rd}, 16'h003C);
        read_mem(16'h0301, rd);
        check("drop_0301", {8'd0, rd}, 16'h0001);

        // Empty load: last on address high byte
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b1);
        check("empty_ld_ready", {15'd0, ld_ready},  16'd0);
        check("empty_rst0",     {15'd0, cpu_reset}, 16'd1);
        @(posedge clk); #1;
        check("empty_rst1",     {15'd0, cpu_reset}, 16'd1);
        @(posedge clk); #1;
        check("empty_rst2",     {15'd0, cpu_reset}, 16'd0);
        read_mem(16'h0300, rd);
        check("empty_0300", {8'd0, rd}, 16'h003C);

        // Reset mid-load
        do_reset();
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'hEE, 1'b1);
        wait_run("pre_wait_run");
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'hD1, 1'b0);
        send_byte(8'hD2, 1'b0);
        send_byte(8'hD3, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 8'hD4;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        check("mid_ld_ready",  {15'd0, ld_ready},  16'd1);
        check("mid_cpu_reset", {15'd0, cpu_reset}, 16'd1);
        check("mid_load_done", {15'd0, load_done}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        read_mem(16'h0400, rd);
        check("mid_0400", {8'd0, rd}, 16'h00D1);
        read_mem(16'h0401, rd);
        check("mid_0401", {8'd0, rd}, 16'h00D2);
        read_mem(16'h0402, rd);
        check("mid_0402", {8'd0, rd}, 16'h00D3);
        read_mem(16'h0403, rd);
        check("mid_0403", {8'd0, rd}, 16'h00EE);
        send_byte(8'h10, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h77, 1'b1);
        wait_run("restart_wait_run");
        read_mem(16'h0410, rd);
        check("restart_0410", {8'd0, rd}, 16'h0077);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
